// File: rtl/conv_window_buffer.sv
// conv_window_buffer
// Sliding K x K window generator for a row-major raster of signed pixels.
// K-1 line buffers hold the most recent complete rows; a K x K shift register
// holds the current window columns. Each accepted pixel with row >= K-1 and
// col >= K-1 loads the window ending at that pixel into a single output stage.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pix_in       signed pixel, row-major, (0,0) first
//   pix_valid    pix_in valid
//   pix_ready    block accepts pix_in this cycle
//   win_data     K*K pixels, element (r,c) at [(r*K+c)*DATA_W +: DATA_W]
//   win_valid    win_data holds a complete window
//   win_ready    downstream consumes the window
//   win_row/col  output-map coordinates of the window
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted
module conv_window_buffer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int DATA_W = 8,
    localparam int OUT_H = IMG_H - K + 1,
    localparam int OUT_W = IMG_W - K + 1,
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [DATA_W-1:0]   pix_in,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic [K*K*DATA_W-1:0]      win_data,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [ROW_W-1:0]           win_row,
    output logic [COL_W-1:0]           win_col,
    output logic                       frame_done
);

    localparam int RC_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CC_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [CC_W-1:0]         col_cnt_q, col_cnt_d;
    logic [RC_W-1:0]         row_cnt_q, row_cnt_d;
    logic                    accept, col_last, row_last, load;

    logic [DATA_W-1:0]       col_new [K];
    logic [DATA_W-1:0]       sr_q    [K][K];
    logic [DATA_W-1:0]       sr_d    [K][K];
    logic [K*K*DATA_W-1:0]   win_pack;

    logic [K*K*DATA_W-1:0]   win_data_q, win_data_d;
    logic                    win_valid_q, win_valid_d;
    logic [ROW_W-1:0]        win_row_q, win_row_d;
    logic [COL_W-1:0]        win_col_q, win_col_d;
    logic                    frame_done_q, frame_done_d;

    assign pix_ready  = !win_valid_q || win_ready;
    assign win_data   = win_data_q;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

    always_comb begin
        accept   = pix_valid && pix_ready;
        col_last = (col_cnt_q == CC_W'(IMG_W - 1));
        row_last = (row_cnt_q == RC_W'(IMG_H - 1));
        // Window rows all come from the current frame once row >= K-1, so
        // stale line-buffer content is never emitted.
        load     = accept && (row_cnt_q >= RC_W'(K - 1)) && (col_cnt_q >= CC_W'(K - 1));
    end

    // Line buffer 0 holds row r-1, buffer i holds row r-1-i. Each accepted
    // pixel pushes the column down by one buffer at the current column.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        logic [DATA_W-1:0] mem [IMG_W];
        if (i == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (accept) mem[col_cnt_q] <= pix_in;
            end
        end else begin : g_rest
            always_ff @(posedge clk) begin
                if (accept) mem[col_cnt_q] <= g_lb[i-1].mem[col_cnt_q];
            end
        end
    end

    // Incoming column, top (oldest row) first, new pixel at the bottom.
    for (genvar rr = 0; rr < K - 1; rr++) begin : g_col
        assign col_new[rr] = g_lb[K-2-rr].mem[col_cnt_q];
    end
    assign col_new[K-1] = pix_in;

    // sr_d is the window after this pixel; it doubles as the load value.
    for (genvar rr = 0; rr < K; rr++) begin : g_sr
        for (genvar cc = 0; cc < K - 1; cc++) begin : g_shift
            assign sr_d[rr][cc] = sr_q[rr][cc+1];
        end
        assign sr_d[rr][K-1] = col_new[rr];
        for (genvar cc = 0; cc < K; cc++) begin : g_pack
            assign win_pack[(rr*K+cc)*DATA_W +: DATA_W] = sr_d[rr][cc];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) sr_q <= sr_d;
    end

    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (accept) begin
            if (col_last) begin
                col_cnt_d = '0;
                row_cnt_d = row_last ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        win_data_d   = win_data_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        win_valid_d  = win_valid_q;
        frame_done_d = accept && col_last && row_last;
        if (load) begin
            win_data_d  = win_pack;
            win_row_d   = ROW_W'(row_cnt_q - RC_W'(K - 1));
            win_col_d   = COL_W'(col_cnt_q - CC_W'(K - 1));
            win_valid_d = 1'b1;
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            win_data_q   <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            win_data_q   <= win_data_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: doc/conv_window_buffer.md
CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

Interface
REQ-001 SHALL provide parameter IMG_W, 28, pixels per image row.
REQ-002 SHALL provide parameter IMG_H, 28, rows per image.
REQ-003 SHALL provide parameter K, 5, square window edge.
REQ-004 SHALL provide parameter DATA_W, 8, signed pixel width.
REQ-005 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL provide port pix_in  input  DATA_W  signed pixel, row-major order, row 0 col 0 first.
REQ-008 SHALL provide port pix_valid  input  1  pix_in holds a valid pixel.
REQ-009 SHALL provide port pix_ready  output  1  block accepts pix_in this cycle.
REQ-010 SHALL provide port win_data  output  K*K*DATA_W  window; element (r,c) at bits [(r*K+c)*DATA_W +: DATA_W], r=0 top row, c=0 left column.
REQ-011 SHALL provide port win_valid  output  1  win_data holds a complete window.
REQ-012 SHALL provide port win_ready  input  1  downstream conv stage consumes the window.
REQ-013 SHALL provide port win_row  output  clog2(IMG_H-K+1)  output-map row of the window (0..23).
REQ-014 SHALL provide port win_col  output  clog2(IMG_W-K+1)  output-map column of the window (0..23).
REQ-015 SHALL provide port frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-016 SHALL accept a pixel exactly when pix_valid && pix_ready.
REQ-017 SHALL drive pix_ready = !win_valid || win_ready (combinational; one output register stage, no pixel is dropped).
REQ-018 SHALL keep input counters col_cnt 0..IMG_W-1 and row_cnt 0..IMG_H-1; col_cnt increments per accepted pixel, wraps to 0 and increments row_cnt at IMG_W-1; both wrap to 0 after pixel (IMG_H-1, IMG_W-1).
REQ-019 SHALL store the K-1 most recent complete rows in line buffers of IMG_W entries each, plus a K x K shift register of the current window columns.
REQ-020 SHALL, on acceptance of pixel (r,c) with r>=K-1 and c>=K-1, register the window whose bottom-right element is (r,c) into win_data, set win_valid the next cycle, win_row=r-(K-1), win_col=c-(K-1).
REQ-021 SHALL not assert win_valid for accepted pixels with r<K-1 or c<K-1; windows never span a row wrap.
REQ-022 SHALL hold win_data, win_row, win_col, win_valid stable while win_valid && !win_ready.
REQ-023 SHALL clear win_valid after a cycle with win_valid && win_ready unless a new window is loaded in that same cycle (simultaneous consume and load keeps win_valid high with new data).
REQ-024 SHALL produce exactly (IMG_H-K+1)*(IMG_W-K+1)=576 windows per frame, ordered win_row-major.
REQ-025 SHALL pulse frame_done for one cycle, registered, the cycle after pixel (IMG_H-1, IMG_W-1) is accepted, coincident with the last window's win_valid rise.
REQ-026 SHALL pass pixel values unmodified, signed, full DATA_W range (-128..127); no saturation or arithmetic.
REQ-027 SHALL start the next frame's pixel (0,0) immediately after the last pixel; no idle cycle required; stale line-buffer rows never produce windows for the new frame before row K-1.

Reset
REQ-028 SHALL, while rst_n low, force win_valid=0, frame_done=0, win_data=0, win_row=0, win_col=0, col_cnt=0, row_cnt=0; line-buffer contents need not be cleared.
REQ-029 SHALL, on reset mid-frame, discard the partial frame and treat the first pixel accepted after deassertion as (0,0).
REQ-030 SHALL drive pix_ready=1 during and directly after reset.

Verification
REQ-031 SHALL pass: ramp frame p(r,c)=3r+c, pix_valid and win_ready always high -> first win_valid the cycle after the 117th accepted pixel, win_row=0, win_col=0, element(0,0)=0, element(4,4)=16; 576 windows total.
REQ-032 SHALL pass: same ramp, window win_row=23, win_col=23 -> element(0,0)=92, element(4,4)=108, frame_done high that cycle only.
REQ-033 SHALL pass: win_ready low 10 cycles while win_valid high -> pix_ready low, win_data/win_row/win_col unchanged, no pixel lost; after release window sequence continues without gap in coordinates.
REQ-034 SHALL pass: rst_n low at pixel (10,7) then new ramp frame -> no win_valid until 117th post-reset pixel, then window (0,0) matches REQ-031.
REQ-035 SHALL pass: frame with pixels -128 and 127 at (4,4) and (0,0) -> window (0,0) element(4,4)=-128, element(0,0)=127.
REQ-036 SHALL pass: two back-to-back frames with random pix_valid gaps -> 1152 windows, all matching a reference model, two frame_done pulses.
